// File: rtl/mac_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_chain_pkg
//  Description : Shared types and constants for the conditional MAC chain
//                sequencer (state encoding, data format, signed compare).
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_chain_pkg;

  // Data format: Q16.16 signed fixed-point
  localparam int W    = 32;
  localparam int FRAC = 16;

  // Controller states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUL_ISSUE = 3'd1,
    ST_MUL_WAIT  = 3'd2,
    ST_ADD_ISSUE = 3'd3,
    ST_ADD_WAIT  = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // True when lhs > rhs, both interpreted as two's-complement words
  function automatic logic signed_gt(input logic [W-1:0] lhs,
                                     input logic [W-1:0] rhs);
    return $signed(lhs) > $signed(rhs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_operand_bank.sv
`default_nettype none
// ============================================================================
//  Module      : mac_operand_bank
//  Description : 2 x N x W operand register file holding the a[] and b[]
//                arrays. One write port; a[i]/b[i] are read combinationally
//                from a registered element index supplied by the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_operand_bank #(
  parameter int N     = 5,
  parameter int W     = 32,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_a,
  output logic [W-1:0]     rd_b
);
  import mac_chain_pkg::*;

  logic [W-1:0] a_mem [N];
  logic [W-1:0] b_mem [N];

  // Write port: an index outside 0..N-1 matches no entry and is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < N; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
      end
    end else if (wr_en) begin
      for (int e = 0; e < N; e++) begin
        if (wr_idx == IDX_W'(e)) begin
          if (wr_sel) b_mem[e] <= wr_data;
          else        a_mem[e] <= wr_data;
        end
      end
    end
  end

  // Read port: explicit decode so an out-of-range index reads zero
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int e = 0; e < N; e++) begin
      if (rd_idx == IDX_W'(e)) begin
        rd_a = a_mem[e];
        rd_b = b_mem[e];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_chain_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mac_chain_sched
//  Description : Evaluates x[i] = x[i-1] +/- a[i]*b[i] over N elements by
//                time-sharing one external multiplier and one external adder
//                through their start/valid handshakes. Returns x[N-1] with a
//                start/valid/busy protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_chain_sched #(
  parameter int N     = 5,
  parameter int W     = 32,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [W-1:0]     result,
  input  logic             ld_en,
  input  logic             ld_sel,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [W-1:0]     ld_data,
  output logic [W-1:0]     mul_op_a,
  output logic [W-1:0]     mul_op_b,
  output logic             mul_start,
  input  logic [W-1:0]     mul_result,
  input  logic             mul_valid,
  output logic [W-1:0]     add_op_a,
  output logic [W-1:0]     add_op_b,
  output logic             add_start,
  input  logic [W-1:0]     add_result,
  input  logic             add_valid
);
  import mac_chain_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     x_acc;
  logic [W-1:0]     prod;
  logic [W-1:0]     mul_a_hold;
  logic [W-1:0]     mul_b_hold;
  logic [W-1:0]     add_a_hold;
  logic [W-1:0]     add_b_hold;
  logic [W-1:0]     rd_a;
  logic [W-1:0]     rd_b;
  logic [W-1:0]     add_b_sel;
  logic             last_elem;
  logic             bank_wr_en;

  // Loads are only honoured while idle, including the cycle start is taken
  assign bank_wr_en = ld_en && (state == ST_IDLE);
  assign last_elem  = (idx == IDX_W'(N - 1));

  // First element always adds; afterwards add only if p > x, else subtract
  assign add_b_sel  = (signed_gt(prod, x_acc) || (idx == '0)) ? prod : (W'(0) - prod);

  mac_operand_bank #(
    .N     (N),
    .W     (W),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bank_wr_en),
    .wr_sel  (ld_sel),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_idx  (idx),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status outputs. Operands are presented live in
  // the ISSUE cycle and replayed from hold registers afterwards, so they
  // only change on ISSUE entry and stay put through the WAIT states.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    valid     = 1'b0;
    mul_start = 1'b0;
    add_start = 1'b0;
    mul_op_a  = mul_a_hold;
    mul_op_b  = mul_b_hold;
    add_op_a  = add_a_hold;
    add_op_b  = add_b_hold;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_MUL_ISSUE;
      end
      ST_MUL_ISSUE: begin
        busy      = 1'b1;
        mul_start = 1'b1;
        mul_op_a  = rd_a;
        mul_op_b  = rd_b;
        state_nxt = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        busy = 1'b1;
        if (mul_valid) state_nxt = ST_ADD_ISSUE;
      end
      ST_ADD_ISSUE: begin
        busy      = 1'b1;
        add_start = 1'b1;
        add_op_a  = x_acc;
        add_op_b  = add_b_sel;
        state_nxt = ST_ADD_WAIT;
      end
      ST_ADD_WAIT: begin
        busy = 1'b1;
        if (add_valid) state_nxt = last_elem ? ST_DONE : ST_MUL_ISSUE;
      end
      ST_DONE: begin
        valid     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: index, accumulator, captured product, operand holds, result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      x_acc      <= '0;
      prod       <= '0;
      mul_a_hold <= '0;
      mul_b_hold <= '0;
      add_a_hold <= '0;
      add_b_hold <= '0;
      result     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx   <= '0;
            x_acc <= '0;
          end
        end
        ST_MUL_ISSUE: begin
          mul_a_hold <= rd_a;
          mul_b_hold <= rd_b;
        end
        ST_MUL_WAIT: begin
          if (mul_valid) prod <= mul_result;
        end
        ST_ADD_ISSUE: begin
          add_a_hold <= x_acc;
          add_b_hold <= add_b_sel;
        end
        ST_ADD_WAIT: begin
          if (add_valid) begin
            x_acc <= add_result;
            // Result is loaded on DONE entry so it is final while valid pulses
            if (last_elem) result <= add_result;
            else           idx    <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_chain_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mac_chain_sched
//  Description : Self-checking bench for mac_chain_sched with behavioural
//                Q16.16 multiplier and adder models of configurable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_chain_sched;

  localparam int N     = 5;
  localparam int N2    = 2;
  localparam int W     = 32;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Main instance (N = 5)
  logic             start, busy, valid;
  logic [W-1:0]     result;
  logic             ld_en, ld_sel;
  logic [IDX_W-1:0] ld_idx;
  logic [W-1:0]     ld_data;
  logic [W-1:0]     mul_op_a, mul_op_b, mul_result;
  logic [W-1:0]     add_op_a, add_op_b, add_result;
  logic             mul_start, mul_valid, add_start, add_valid;

  // Second instance (N = 2)
  logic             start2, busy2, valid2;
  logic [W-1:0]     result2;
  logic             ld_en2, ld_sel2;
  logic [IDX_W-1:0] ld_idx2;
  logic [W-1:0]     ld_data2;
  logic [W-1:0]     mul_op_a2, mul_op_b2, mul_result2;
  logic [W-1:0]     add_op_a2, add_op_b2, add_result2;
  logic             mul_start2, mul_valid2, add_start2, add_valid2;

  mac_chain_sched #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .valid(valid),
    .result(result), .ld_en(ld_en), .ld_sel(ld_sel), .ld_idx(ld_idx),
    .ld_data(ld_data), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
    .mul_start(mul_start), .mul_result(mul_result), .mul_valid(mul_valid),
    .add_op_a(add_op_a), .add_op_b(add_op_b), .add_start(add_start),
    .add_result(add_result), .add_valid(add_valid)
  );

  mac_chain_sched #(.N(N2), .W(W), .IDX_W(IDX_W)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .valid(valid2),
    .result(result2), .ld_en(ld_en2), .ld_sel(ld_sel2), .ld_idx(ld_idx2),
    .ld_data(ld_data2), .mul_op_a(mul_op_a2), .mul_op_b(mul_op_b2),
    .mul_start(mul_start2), .mul_result(mul_result2), .mul_valid(mul_valid2),
    .add_op_a(add_op_a2), .add_op_b(add_op_b2), .add_start(add_start2),
    .add_result(add_result2), .add_valid(add_valid2)
  );

  // ---------------- operator models ----------------
  int   lm = 1;
  int   la = 1;
  logic stray = 1'b0;

  function automatic logic [W-1:0] qmul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint pr;
    pr = longint'($signed(x)) * longint'($signed(y));
    return pr[47:16];
  endfunction

  int mcnt = 0, acnt = 0, mcnt2 = 0, acnt2 = 0;
  logic [W-1:0] mprod = '0, asum = '0, mprod2 = '0, asum2 = '0;

  // Models are not tied to the DUT reset, so pending valids still arrive
  always @(posedge clk) begin
    if (mul_start) begin mcnt <= lm; mprod <= qmul(mul_op_a, mul_op_b); end
    else if (mcnt > 0) mcnt <= mcnt - 1;
    if (add_start) begin acnt <= la; asum <= add_op_a + add_op_b; end
    else if (acnt > 0) acnt <= acnt - 1;
    if (mul_start2) begin mcnt2 <= lm; mprod2 <= qmul(mul_op_a2, mul_op_b2); end
    else if (mcnt2 > 0) mcnt2 <= mcnt2 - 1;
    if (add_start2) begin acnt2 <= la; asum2 <= add_op_a2 + add_op_b2; end
    else if (acnt2 > 0) acnt2 <= acnt2 - 1;
  end

  assign mul_valid   = (mcnt == 1) || stray;
  assign mul_result  = mprod;
  assign add_valid   = (acnt == 1) || stray;
  assign add_result  = asum;
  assign mul_valid2  = (mcnt2 == 1);
  assign mul_result2 = mprod2;
  assign add_valid2  = (acnt2 == 1);
  assign add_result2 = asum2;

  // ---------------- checking ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, act, act, exp, exp);
    end
  endtask

  logic [W-1:0] sb_q[$];
  int           valid_cnt = 0;
  logic         stab_on = 1'b1;
  logic         mpend = 1'b0, apend = 1'b0;
  logic [W-1:0] ma_l, mb_l, aa_l, ab_l;

  // Scoreboard and operand-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      if (sb_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected valid: got result 0x%08h, expected no valid", result);
      end else begin
        check("scoreboard result", result, sb_q.pop_front());
      end
    end
    if (!stab_on) begin
      mpend = 1'b0;
      apend = 1'b0;
    end else begin
      if (mpend) begin
        check("mul_op_a stable", mul_op_a, ma_l);
        check("mul_op_b stable", mul_op_b, mb_l);
        if (mul_valid) mpend = 1'b0;
      end
      if (mul_start) begin mpend = 1'b1; ma_l = mul_op_a; mb_l = mul_op_b; end
      if (apend) begin
        check("add_op_a stable", add_op_a, aa_l);
        check("add_op_b stable", add_op_b, ab_l);
        if (add_valid) apend = 1'b0;
      end
      if (add_start) begin apend = 1'b1; aa_l = add_op_a; ab_l = add_op_b; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input logic sel, input logic [IDX_W-1:0] idx, input logic [W-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_idx = idx; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load2(input logic sel, input logic [IDX_W-1:0] idx, input logic [W-1:0] d);
    @(negedge clk);
    ld_en2 = 1'b1; ld_sel2 = sel; ld_idx2 = idx; ld_data2 = d;
    @(negedge clk);
    ld_en2 = 1'b0;
  endtask

  // Start a run, optionally poke start/ld_en at cycle 'poke', check timing
  task automatic run_chain(input logic [W-1:0] exp_res, input int exp_cyc, input int poke);
    int cyc;
    int v0;
    v0 = valid_cnt;
    sb_q.push_back(exp_res);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy in cycle 1", busy, 1);
    check("mul_start in cycle 1", mul_start, 1);
    while (!valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke) begin
        start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_idx = '0; ld_data = '0;
      end else if (cyc == poke + 1) begin
        start = 1'b0; ld_en = 1'b0;
      end
    end
    check("valid cycle", cyc, exp_cyc);
    check("busy low with valid", busy, 0);
    if (!valid) sb_q.delete();
    repeat (12) @(negedge clk);
    check("valid pulse count", valid_cnt - v0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int                   lm;
    int                   la;
    bit                   reload;
    logic [N-1:0][W-1:0]  a;
    logic [N-1:0][W-1:0]  b;
    logic [W-1:0]         exp_res;
    int                   exp_cyc;
    int                   poke;
  } vec_t;

  vec_t vecs[3];
  int   v0;
  int   cyc2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_idx = '0; ld_data = '0;
    start2 = 1'b0; ld_en2 = 1'b0; ld_sel2 = 1'b0; ld_idx2 = '0; ld_data2 = '0;

    // Basic chain, Lm=La=1; start/ld_en poked in cycle 5
    vecs[0].lm = 1; vecs[0].la = 1; vecs[0].reload = 1'b1;
    for (int k = 0; k < N; k++) begin
      vecs[0].a[k] = W'((k + 1) * 65536);
      vecs[0].b[k] = W'((k + 7) * 65536);
    end
    vecs[0].exp_res = 32'd4259840; vecs[0].exp_cyc = 21; vecs[0].poke = 5;
    // Same operands without reloading, Lm=3 La=2
    vecs[1] = vecs[0];
    vecs[1].lm = 3; vecs[1].la = 2; vecs[1].reload = 1'b0;
    vecs[1].exp_cyc = 36; vecs[1].poke = -1;
    // Negative products and p == x ties: 2, -1, 3, 0, -5 -> 2,3,0,0,5
    vecs[2].lm = 2; vecs[2].la = 1; vecs[2].reload = 1'b1;
    for (int k = 0; k < N; k++) vecs[2].a[k] = 32'h0001_0000;
    vecs[2].b[0] = 32'h0002_0000; vecs[2].b[1] = 32'hFFFF_0000;
    vecs[2].b[2] = 32'h0003_0000; vecs[2].b[3] = 32'h0000_0000;
    vecs[2].b[4] = 32'hFFFB_0000;
    vecs[2].exp_res = 32'd327680; vecs[2].exp_cyc = 26; vecs[2].poke = -1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset valid", valid, 0);
    check("reset result", result, 0);
    check("reset mul_start", mul_start, 0);
    check("reset add_start", add_start, 0);
    check("reset mul_op_a", mul_op_a, 0);
    check("reset mul_op_b", mul_op_b, 0);
    check("reset add_op_a", add_op_a, 0);
    check("reset add_op_b", add_op_b, 0);
    reset = 1'b1;

    for (int v = 0; v < 3; v++) begin
      lm = vecs[v].lm;
      la = vecs[v].la;
      if (vecs[v].reload) begin
        for (int k = 0; k < N; k++) begin
          load(1'b0, IDX_W'(k), vecs[v].a[k]);
          load(1'b1, IDX_W'(k), vecs[v].b[k]);
        end
        load(1'b0, 3'd7, 32'h7FFF_0000);
        load(1'b1, 3'd5, 32'h7FFF_0000);
      end
      run_chain(vecs[v].exp_res, vecs[v].exp_cyc, vecs[v].poke);
    end

    // Reset in cycle 10 of a run, with stray valids afterwards
    stab_on = 1'b0; lm = 1; la = 1; v0 = valid_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0; stray = 1'b1;
    #1;
    check("mid-reset busy", busy, 0);
    check("mid-reset valid", valid, 0);
    check("mid-reset result", result, 0);
    check("mid-reset mul_start", mul_start, 0);
    check("mid-reset add_start", add_start, 0);
    check("mid-reset mul_op_a", mul_op_a, 0);
    check("mid-reset mul_op_b", mul_op_b, 0);
    check("mid-reset add_op_a", add_op_a, 0);
    check("mid-reset add_op_b", add_op_b, 0);
    @(negedge clk); reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post-reset valid", valid, 0);
      check("post-reset busy", busy, 0);
    end
    stray = 1'b0;
    repeat (4) @(negedge clk);
    check("no valid after reset", valid_cnt - v0, 0);
    stab_on = 1'b1;
    // Arrays were cleared: all-zero operands give zero
    run_chain(32'd0, 21, -1);

    // N=2 instance: out-of-range writes dropped, load in the start cycle,
    // subtract of a negative product
    load2(1'b0, 3'd0, 32'h0001_0000);
    load2(1'b0, 3'd1, 32'h0001_0000);
    load2(1'b1, 3'd0, 32'h0001_0000);
    load2(1'b0, 3'd7, 32'h7FFF_0000);
    load2(1'b0, 3'd2, 32'h7FFF_0000);
    @(negedge clk);
    start2 = 1'b1; ld_en2 = 1'b1; ld_sel2 = 1'b1; ld_idx2 = 3'd1; ld_data2 = 32'hFFFD_0000;
    @(negedge clk);
    start2 = 1'b0; ld_en2 = 1'b0;
    cyc2 = 1;
    check("n2 busy in cycle 1", busy2, 1);
    while (!valid2 && cyc2 < 100) begin
      @(negedge clk);
      cyc2++;
    end
    check("n2 valid", valid2, 1);
    check("n2 valid cycle", cyc2, 9);
    check("n2 result", result2, 32'd262144);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
